// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first, one full-subtractor cell reused WIDTH times.
// start/done handshake; diff and bout update only when an operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CNT_W-1:0] count;

  logic             d_c;
  logic             borrow_next_c;
  logic             last_bit_c;
  logic             busy_next_c;
  logic             done_next_c;

  // Single full-subtractor cell operating on the current LSBs
  always_comb begin
    d_c           = sa[0] ^ sb[0] ^ borrow;
    borrow_next_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    last_bit_c    = (count == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done can be registered
  always_comb begin
    busy_next_c = 1'b0;
    done_next_c = 1'b0;
    case (next_state)
      SHIFT:   busy_next_c = 1'b1;
      DONE: begin
        busy_next_c = 1'b1;
        done_next_c = 1'b1;
      end
      default: begin
        busy_next_c = 1'b0;
        done_next_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next_c;
      done <= done_next_c;
    end
  end

  // Operand capture, bit-serial shifting and result publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            count  <= '0;
          end
        end
        SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= {d_c, res[WIDTH-1:1]};
          borrow <= borrow_next_c;
          count  <= count + CNT_W'(1);
          if (last_bit_c) begin
            diff <= {d_c, res[WIDTH-1:1]};
            bout <= borrow_next_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8,
// compared against plain modular arithmetic.
module tb_serial_subtractor;

  logic clk;
  logic reset;

  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks;
  int errors;
  int prev_d[2];
  int prev_b[2];

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_busy(input int w);
    return (w == 8) ? 32'(busy8) : 32'(busy4);
  endfunction
  function automatic logic [31:0] get_done(input int w);
    return (w == 8) ? 32'(done8) : 32'(done4);
  endfunction
  function automatic logic [31:0] get_diff(input int w);
    return (w == 8) ? 32'(diff8) : 32'(diff4);
  endfunction
  function automatic logic [31:0] get_bout(input int w);
    return (w == 8) ? 32'(bout8) : 32'(bout4);
  endfunction

  task automatic drive(input int w, input logic s, input int av, input int bv, input int bi);
    if (w == 8) begin
      start8 = s; a8 = 8'(av); b8 = 8'(bv); bin8 = 1'(bi);
    end else begin
      start4 = s; a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bi);
    end
  endtask

  // One full operation; operands are disturbed after acceptance (nav >= 0 forces a to nav)
  task automatic do_op(input int w, input int av, input int bv, input int bi, input int nav);
    int lat;
    int idx;
    int exp_d;
    int exp_b;
    logic seen;
    idx   = (w == 8) ? 1 : 0;
    exp_d = (av - bv - bi) & ((1 << w) - 1);
    exp_b = (av < (bv + bi)) ? 1 : 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv, bi);
    @(posedge clk); #1;
    check("busy_after_accept", get_busy(w), 32'd1);
    if (nav >= 0) drive(w, 1'b0, nav, bv, bi);
    else drive(w, 1'b0, int'($urandom), int'($urandom), int'($urandom_range(1, 0)));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < w + 4) begin
      @(posedge clk); #1;
      lat++;
      if (get_done(w) == 32'd1) seen = 1'b1;
      else if (lat == 1) begin
        check("diff_hold", get_diff(w), 32'(prev_d[idx]));
        check("bout_hold", get_bout(w), 32'(prev_b[idx]));
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(w));
    check("diff", get_diff(w), 32'(exp_d));
    check("bout", get_bout(w), 32'(exp_b));
    check("busy_in_done", get_busy(w), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", get_done(w), 32'd0);
    check("idle_after_done", get_busy(w), 32'd0);
    check("diff_stable", get_diff(w), 32'(exp_d));
    prev_d[idx] = exp_d;
    prev_b[idx] = exp_b;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_d = '{0, 0};
    prev_b = '{0, 0};
    reset  = 1'b1;
    drive(4, 1'b0, 0, 0, 0);
    drive(8, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy4", get_busy(4), 32'd0);
    check("rst_done4", get_done(4), 32'd0);
    check("rst_diff4", get_diff(4), 32'd0);
    check("rst_bout4", get_bout(4), 32'd0);
    check("rst_busy8", get_busy(8), 32'd0);
    check("rst_diff8", get_diff(8), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed 4-bit cases, including the wrap case
    do_op(4, 9, 3, 0, -1);
    do_op(4, 3, 9, 0, -1);
    do_op(4, 0, 0, 1, -1);
    do_op(4, 0, 15, 1, -1);
    do_op(4, 7, 2, 0, 1);

    // start held high: one accept per 6 cycles, done pulses exactly one cycle
    @(negedge clk);
    drive(4, 1'b1, 5, 2, 0);
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      check("held_done", get_done(4), ((k % 6) == 4) ? 32'd1 : 32'd0);
      check("held_busy", get_busy(4), ((k % 6) == 5) ? 32'd0 : 32'd1);
      if ((k % 6) == 4) check("held_diff", get_diff(4), 32'd3);
    end
    @(negedge clk);
    drive(4, 1'b0, 0, 0, 0);
    prev_d[0] = 3;
    prev_b[0] = 0;
    repeat (2) @(posedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    drive(4, 1'b1, 12, 4, 0);
    @(posedge clk); #1;
    drive(4, 1'b0, 12, 4, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", get_busy(4), 32'd0);
    check("midrst_done", get_done(4), 32'd0);
    check("midrst_diff", get_diff(4), 32'd0);
    check("midrst_bout", get_bout(4), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_d = '{0, 0};
    prev_b = '{0, 0};
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", get_done(4), 32'd0);
    end
    do_op(4, 12, 4, 0, -1);

    // Random 4-bit operations
    for (int i = 0; i < 30; i++)
      do_op(4, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
            int'($urandom_range(1, 0)), -1);

    // 8-bit directed and random
    do_op(8, 200, 55, 1, -1);
    do_op(8, 55, 200, 0, -1);
    do_op(8, 0, 255, 1, -1);
    for (int i = 0; i < 20; i++)
      do_op(8, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(1, 0)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
